dbus_uart_tx: RTL and testbench

//  Host-side consumer of the dbus byte interface. Pulls received link bytes via the
//  o_avail/o_data/i_read handshake and buffers them in a small FIFO. Serialises each

---
 rtl/dbus_uart_tx_pkg.sv | 25 ++
 rtl/dbus_uart_tx_byte_fifo.sv | 58 +++++
 rtl/dbus_uart_tx.sv | 193 +++++++++++++++++++
 tb/tb_dbus_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_uart_tx_pkg.sv
// Shared definitions for the dbus -> UART transmit bridge: FSM state
// encodings, the default clock rate and the dbus handshake latency.
package dbus_uart_tx_pkg;

  // dbus drops o_avail this many cycles after it samples i_read.
  localparam int DBUS_READ_LATENCY = 2;

  // Default system clock frequency in Hz.
  localparam int DEFAULT_CLOCKFREQ = 4000000;

  // Fetch side: idle, or holding off while dbus retires the acknowledged byte.
  typedef enum logic {
    F_IDLE = 1'b0,
    F_HOLD = 1'b1
  } fetch_state_t;

  // Transmit side: one state per frame section.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/dbus_uart_tx_byte_fifo.sv
// First-word-fall-through byte FIFO. The head byte is always visible on
// o_dout while non-empty; a push shows up in o_level on the next cycle.
module dbus_uart_tx_byte_fifo #(
  parameter int c_DEPTH = 16
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [7:0]                 i_din,
  input  logic                       i_pop,
  output logic [7:0]                 o_dout,
  output logic [$clog2(c_DEPTH):0]   o_level,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int              c_AW   = $clog2(c_DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(c_DEPTH);

  logic [7:0]      r_mem [c_DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_level;
  logic            w_wr;
  logic            w_rd;

  assign o_full  = (r_level == c_FULL);
  assign o_empty = (r_level == '0);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage array; no reset so it maps onto distributed RAM.
  always_ff @(posedge i_clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap freely.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (c_AW + 1)'(1);
        2'b01:   r_level <= r_level - (c_AW + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/dbus_uart_tx.sv
// Link -> host half of the bridge: pulls bytes from the dbus handshake into
// a FIFO and shifts them out as 8N1/8N2 UART frames, LSB first.
module dbus_uart_tx
  import dbus_uart_tx_pkg::*;
#(
  parameter int c_CLOCKFREQ = DEFAULT_CLOCKFREQ,
  parameter int c_BAUD      = 9600,
  parameter int c_FIFODEPTH = 16,
  parameter int c_STOPBITS  = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_avail,
  input  logic [7:0]                    i_data,
  output logic                          o_read,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(c_FIFODEPTH):0]  o_level
);

  localparam int               c_DIV       = c_CLOCKFREQ / c_BAUD;
  localparam int               c_CW        = $clog2(c_DIV);
  localparam logic [c_CW-1:0]  c_DIV_M1    = c_CW'(c_DIV - 1);
  localparam int               c_HW        = (DBUS_READ_LATENCY > 1) ? $clog2(DBUS_READ_LATENCY) : 1;
  localparam logic [c_HW-1:0]  c_HOLD_LAST = c_HW'(DBUS_READ_LATENCY - 1);
  localparam logic             c_LAST_STOP = (c_STOPBITS == 2);

  // Fetch side
  fetch_state_t                r_fstate, w_fstate_next;
  logic [c_HW-1:0]             r_hold_cnt;
  logic                        r_read;
  logic [7:0]                  r_data;
  logic                        w_fetch;

  // FIFO
  logic [7:0]                  w_dout;
  logic [$clog2(c_FIFODEPTH):0] w_level;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_pop;

  // Transmit side
  tx_state_t                   r_tx_state, w_tx_state_next;
  logic [c_CW-1:0]             r_baud_cnt, w_baud_cnt_next;
  logic [2:0]                  r_bit_idx, w_bit_idx_next;
  logic [7:0]                  r_shift, w_shift_next;
  logic                        r_stop_idx, w_stop_idx_next;
  logic                        r_tx, w_tx_next;
  logic                        r_busy;

  // The acknowledged byte is pushed one cycle after o_read rises, so the
  // FIFO sees it at the same time as the level update.
  dbus_uart_tx_byte_fifo #(
    .c_DEPTH (c_FIFODEPTH)
  ) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (r_read),
    .i_din   (r_data),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Fetch next-state: take a byte only when idle and there is room.
  always_comb begin
    w_fstate_next = r_fstate;
    w_fetch       = 1'b0;
    case (r_fstate)
      F_IDLE: begin
        if (i_avail && !w_full) begin
          w_fetch       = 1'b1;
          w_fstate_next = F_HOLD;
        end
      end
      F_HOLD: begin
        if (r_hold_cnt == c_HOLD_LAST) w_fstate_next = F_IDLE;
      end
      default: w_fstate_next = F_IDLE;
    endcase
  end

  // Fetch registers: one-cycle acknowledge, captured byte, hold-off counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fstate   <= F_IDLE;
      r_hold_cnt <= '0;
      r_read     <= 1'b0;
      r_data     <= '0;
    end else begin
      r_fstate <= w_fstate_next;
      r_read   <= w_fetch;
      if (w_fetch) r_data <= i_data;
      if (r_fstate == F_HOLD) r_hold_cnt <= r_hold_cnt + c_HW'(1);
      else                    r_hold_cnt <= '0;
    end
  end

  // Transmit next-state: every bit period counts c_DIV-1 down to 0.
  always_comb begin
    w_tx_state_next = r_tx_state;
    w_baud_cnt_next = r_baud_cnt;
    w_bit_idx_next  = r_bit_idx;
    w_shift_next    = r_shift;
    w_stop_idx_next = r_stop_idx;
    w_tx_next       = r_tx;
    w_pop           = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop           = 1'b1;
          w_shift_next    = w_dout;
          w_baud_cnt_next = c_DIV_M1;
          w_tx_state_next = S_START;
          w_tx_next       = 1'b0;
        end
      end
      S_START: begin
        if (r_baud_cnt == '0) begin
          w_baud_cnt_next = c_DIV_M1;
          w_bit_idx_next  = 3'd0;
          w_tx_state_next = S_DATA;
          w_tx_next       = r_shift[0];
        end else begin
          w_baud_cnt_next = r_baud_cnt - c_CW'(1);
        end
      end
      S_DATA: begin
        if (r_baud_cnt == '0) begin
          w_baud_cnt_next = c_DIV_M1;
          if (r_bit_idx == 3'd7) begin
            w_tx_state_next = S_STOP;
            w_stop_idx_next = 1'b0;
            w_tx_next       = 1'b1;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
            w_shift_next   = {1'b0, r_shift[7:1]};
            w_tx_next      = r_shift[1];
          end
        end else begin
          w_baud_cnt_next = r_baud_cnt - c_CW'(1);
        end
      end
      S_STOP: begin
        if (r_baud_cnt != '0) begin
          w_baud_cnt_next = r_baud_cnt - c_CW'(1);
        end else if (r_stop_idx != c_LAST_STOP) begin
          w_stop_idx_next = 1'b1;
          w_baud_cnt_next = c_DIV_M1;
        end else if (!w_empty) begin
          // Back-to-back frame: next start bit follows the stop with no gap.
          w_pop           = 1'b1;
          w_shift_next    = w_dout;
          w_baud_cnt_next = c_DIV_M1;
          w_tx_state_next = S_START;
          w_tx_next       = 1'b0;
        end else begin
          w_tx_state_next = S_IDLE;
        end
      end
      default: w_tx_state_next = S_IDLE;
    endcase
  end

  // Transmit registers; reset drives the line idle and abandons any frame.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tx_state <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_next;
      r_baud_cnt <= w_baud_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
      r_stop_idx <= w_stop_idx_next;
      r_tx       <= w_tx_next;
      r_busy     <= (w_level != '0) || (r_tx_state != S_IDLE);
    end
  end

  assign o_read  = r_read;
  assign o_tx    = r_tx;
  assign o_busy  = r_busy;
  assign o_level = w_level;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Bench for dbus_uart_tx: a 9600-baud/16-deep instance checked cycle-exactly
// against expected frame waveforms, and a fast 4-deep 8N2 instance checked
// by a mid-bit UART decoder and a byte scoreboard.
module tb_dbus_uart_tx;

  localparam int DIV_A = 416;
  localparam int DIV_B = 8;

  logic       clk;
  logic       rst_a, avail_a, read_a, tx_a, busy_a;
  logic [7:0] data_a;
  logic [4:0] level_a;
  logic       rst_b, avail_b, read_b, tx_b, busy_b;
  logic [7:0] data_b;
  logic [2:0] level_b;

  int    n_checks = 0;
  int    n_err    = 0;
  longint cyc     = 0;

  dbus_uart_tx #(.c_CLOCKFREQ(4000000), .c_BAUD(9600), .c_FIFODEPTH(16), .c_STOPBITS(1)) dut_a (
    .i_clock(clk), .i_reset(rst_a), .i_avail(avail_a), .i_data(data_a),
    .o_read(read_a), .o_tx(tx_a), .o_busy(busy_a), .o_level(level_a));

  dbus_uart_tx #(.c_CLOCKFREQ(4000000), .c_BAUD(500000), .c_FIFODEPTH(4), .c_STOPBITS(2)) dut_b (
    .i_clock(clk), .i_reset(rst_b), .i_avail(avail_b), .i_data(data_b),
    .o_read(read_b), .o_tx(tx_b), .o_busy(busy_b), .o_level(level_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // dbus models: present queued bytes, keep o_avail for 2 cycles after the
  // acknowledge is seen, then retire the byte.
  byte unsigned q_a[$];
  byte unsigned q_b[$];
  byte unsigned exp_b[$];
  int reads_a = 0, reads_b = 0, hold_a = 0, hold_b = 0, viol_b = 0;

  initial begin
    avail_a = 1'b0;
    data_a  = '0;
    forever begin
      step(1);
      if (read_a) begin
        reads_a++;
        hold_a = 2;
      end else if (hold_a > 0) begin
        hold_a--;
        if (hold_a == 0) begin
          void'(q_a.pop_front());
          avail_a = 1'b0;
        end
      end
      if (hold_a == 0 && !avail_a && q_a.size() != 0) begin
        avail_a = 1'b1;
        data_a  = q_a[0];
      end
    end
  end

  initial begin
    avail_b = 1'b0;
    data_b  = '0;
    forever begin
      step(1);
      if (read_b) begin
        reads_b++;
        exp_b.push_back(data_b);
        if (level_b == 3'd4) viol_b++;
        hold_b = 2;
      end else if (hold_b > 0) begin
        hold_b--;
        if (hold_b == 0) begin
          void'(q_b.pop_front());
          avail_b = 1'b0;
        end
      end
      if (hold_b == 0 && !avail_b && q_b.size() != 0) begin
        avail_b = 1'b1;
        data_b  = q_b[0];
      end
    end
  end

  // UART receiver for dut_b: find the start edge, sample each bit mid-period.
  int     dec_b = 0;
  longint starts_b[$];
  initial begin
    logic [7:0]   d;
    bit           ok;
    byte unsigned e;
    forever begin
      step(1);
      if (!rst_b && tx_b == 1'b0) begin
        starts_b.push_back(cyc);
        step(DIV_B / 2);
        ok = (tx_b == 1'b0);
        for (int k = 0; k < 8; k++) begin
          step(DIV_B);
          d[k] = tx_b;
        end
        for (int s = 0; s < 2; s++) begin
          step(DIV_B);
          if (tx_b !== 1'b1) ok = 1'b0;
        end
        if (exp_b.size() == 0) begin
          check(1'b0, "b_unexpected_frame", d, 0);
        end else begin
          e = exp_b.pop_front();
          check(ok && (d == e), "b_frame", {ok, d}, {1'b1, e});
        end
        dec_b++;
        $display("txn: dut_b received byte 0x%02h framing_ok=%0d", d, ok);
      end
    end
  end

  // Compare dut_a's line against a frame pattern cycle by cycle, starting at
  // the first cycle of the start bit. pat[0] = start, pat[8:1] = data, pat[9] = stop.
  task automatic expect_frame_a(input logic [9:0] pat, input string name);
    int bad;
    bad = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < DIV_A; c++) begin
        if (tx_a !== pat[b]) bad++;
        step(1);
      end
    end
    check(bad == 0, name, bad, 0);
    $display("txn: dut_a frame 0x%02h compared, %0d wrong cycles", pat[8:1], bad);
  endtask

  task automatic wait_read_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (read_a) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    check(ok, "a_read_timeout", ok, 1);
  endtask

  task automatic wait_dec_b(input int target, input int budget);
    for (int i = 0; i < budget && dec_b < target; i++) step(1);
    check(dec_b == target, "b_decoded_count", dec_b, target);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] pat;
  } vec_t;
  vec_t vecs [5];

  initial begin
    bit ok;
    int bad;
    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h3C, 10'h278};
    vecs[4] = '{8'h81, 10'h302};

    // Reset state
    rst_a = 1'b1;
    rst_b = 1'b1;
    step(2);
    check(tx_a == 1'b1, "rst_tx", tx_a, 1);
    check(read_a == 1'b0, "rst_read", read_a, 0);
    check(busy_a == 1'b0, "rst_busy", busy_a, 0);
    check(level_a == 5'd0, "rst_level", level_a, 0);
    check(tx_b == 1'b1 && level_b == 3'd0, "rst_b", {tx_b, level_b}, 4'h8);
    rst_a = 1'b0;
    rst_b = 1'b0;
    step(2);

    // Single bytes: latency, exact frame waveform, busy, one acknowledge each
    for (int i = 0; i < 5; i++) begin
      q_a.push_back(vecs[i].data);
      wait_read_a(ok);
      if (ok) begin
        step(1);
        check(level_a == 5'd1, "a_level_after_push", level_a, 1);
        check(tx_a == 1'b1, "a_tx_before_start", tx_a, 1);
        step(1);
        check(busy_a == 1'b1, "a_busy_in_frame", busy_a, 1);
        expect_frame_a(vecs[i].pat, "a_frame");
        step(2);
        check(busy_a == 1'b0 && tx_a == 1'b1, "a_idle_after_frame", {busy_a, tx_a}, 2'b01);
      end
      check(reads_a == i + 1, "a_read_count", reads_a, i + 1);
    end

    // Back-to-back 0x00, 0xFF: stop lasts one bit, next start immediately
    q_a.push_back(8'h00);
    q_a.push_back(8'hFF);
    wait_read_a(ok);
    if (ok) begin
      step(2);
      expect_frame_a(10'h200, "a_b2b_first");
      expect_frame_a(10'h3FE, "a_b2b_second");
    end
    step(2);
    check(reads_a == 7, "a_b2b_read_count", reads_a, 7);

    // Reset during data bit 3 of 0x3C with two bytes queued
    q_a.push_back(8'h3C);
    q_a.push_back(8'h11);
    q_a.push_back(8'h22);
    wait_read_a(ok);
    if (ok) begin
      step(2 + 4 * DIV_A + DIV_A / 2);
      check(level_a == 5'd2, "a_level_queued", level_a, 2);
      rst_a = 1'b1;
      step(1);
      check(tx_a == 1'b1, "a_tx_after_reset", tx_a, 1);
      check(level_a == 5'd0, "a_level_after_reset", level_a, 0);
      step(1);
      rst_a = 1'b0;
      bad = 0;
      for (int c = 0; c < 5 * DIV_A; c++) begin
        if (tx_a !== 1'b1) bad++;
        step(1);
      end
      check(bad == 0, "a_line_idle_after_abort", bad, 0);
      check(busy_a == 1'b0, "a_busy_after_abort", busy_a, 0);
    end
    check(reads_a == 10, "a_abort_read_count", reads_a, 10);
    q_a.push_back(8'h81);
    wait_read_a(ok);
    if (ok) begin
      step(2);
      expect_frame_a(10'h302, "a_frame_after_reset");
    end

    // dut_b: 20 bytes back-to-back into a 4-deep FIFO, 8N2
    starts_b.delete();
    for (int i = 0; i < 20; i++) q_b.push_back(byte'(i));
    wait_dec_b(20, 4000);
    check(viol_b == 0, "b_read_while_full", viol_b, 0);
    check(reads_b == 20, "b_read_count", reads_b, 20);
    bad = 0;
    for (int i = 1; i < starts_b.size(); i++) begin
      if (starts_b[i] - starts_b[i-1] != 11 * DIV_B) bad++;
    end
    check(bad == 0 && starts_b.size() == 20, "b_frame_spacing", bad, 0);

    // dut_b: random bytes with random gaps
    for (int i = 0; i < 30; i++) begin
      step($urandom_range(0, 40));
      q_b.push_back(byte'($urandom_range(0, 255)));
    end
    wait_dec_b(50, 6000);
    check(reads_b == 50, "b_random_read_count", reads_b, 50);
    check(exp_b.size() == 0, "b_scoreboard_empty", exp_b.size(), 0);
    check(viol_b == 0, "b_random_read_while_full", viol_b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
